// File: rtl/buzzer_sequencer.sv
// ---------------------------------------------------------------------------
// buzzer_sequencer
//
// Converts single-cycle event requests from the quiz-responder control logic
// into timed, mutually exclusive level commands for the buzzer tone
// generator.
//
//   TimeOver_Req > Answer_Req > True_Req   (fixed priority)
//
// A time-over request preempts a running answer or true tone. The time-over
// tone is played as TO_BEEPS beeps of TO_ON_TICKS cycles each. The beeps are
// separated by gaps of TO_OFF_TICKS cycles.
//
// Optional build macro:
//   BUZZER_QUEUE_EN  - keep one pending flag per Answer/True request type.
//                      Requests that lose arbitration or arrive while busy
//                      are replayed at termination in priority order.
//                      Without it such requests are dropped.
//
// Ports:
//   CLK              system clock, rising edge
//   RST              asynchronous active-high reset
//   Answer_Req       pulse: first responder locked
//   True_Req         pulse: answer judged correct
//   TimeOver_Req     pulse: answer time expired
//   Mute             level: abort any tone, block requests
//   Buzzer_Answer    high for the whole answer tone
//   Answer_true      high for the whole correct-answer tone
//   Buzzer_TimeOver  high during time-over beeps
//   TimeOver_Stop    high over the whole time-over pattern (beeps and gaps)
//   Busy             sequencer not idle
//   Done             one-cycle pulse after a normally completed sequence
// ---------------------------------------------------------------------------
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | no tone; requests arbitrated every cycle
//  S_ANS    | answer tone, ANS_TICKS cycles
//  S_TRUE   | correct-answer tone, TRUE_TICKS cycles
//  S_TO_ON  | time-over beep, TO_ON_TICKS cycles; bcnt counts beeps
//  S_TO_OFF | silent gap between beeps, TO_OFF_TICKS cycles
//
module buzzer_sequencer #(
   parameter int ANS_TICKS    = 25_000_000,
   parameter int TRUE_TICKS   = 50_000_000,
   parameter int TO_ON_TICKS  = 12_500_000,
   parameter int TO_OFF_TICKS = 12_500_000,
   parameter int TO_BEEPS     = 3,
   parameter int CNT_W        = 26
) (
   input  logic CLK,
   input  logic RST,
   input  logic Answer_Req,
   input  logic True_Req,
   input  logic TimeOver_Req,
   input  logic Mute,
   output logic Buzzer_Answer,
   output logic Answer_true,
   output logic Buzzer_TimeOver,
   output logic TimeOver_Stop,
   output logic Busy,
   output logic Done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ANS    = 3'd1;
   localparam logic [2:0] S_TRUE   = 3'd2;
   localparam logic [2:0] S_TO_ON  = 3'd3;
   localparam logic [2:0] S_TO_OFF = 3'd4;

   localparam logic [CNT_W-1:0] ANS_LAST    = CNT_W'(ANS_TICKS - 1);
   localparam logic [CNT_W-1:0] TRUE_LAST   = CNT_W'(TRUE_TICKS - 1);
   localparam logic [CNT_W-1:0] TO_ON_LAST  = CNT_W'(TO_ON_TICKS - 1);
   localparam logic [CNT_W-1:0] TO_OFF_LAST = CNT_W'(TO_OFF_TICKS - 1);
   localparam logic [3:0]       BEEPS_LAST  = 4'(TO_BEEPS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef BUZZER_QUEUE_EN
   localparam logic QUEUE_EN = 1'b1;
`else
   localparam logic QUEUE_EN = 1'b0;
`endif

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bcnt_q, bcnt_d;
   logic             done_d;

   // Pending flags. A time-over request never waits: it either wins or
   // preempts, or it is ignored inside its own pattern. So only the answer
   // and true requests need a flag. Without the queue the flags stay at
   // zero and synthesis removes them.
   logic             pend_ans_q, pend_ans_d;
   logic             pend_true_q, pend_true_d;

   logic             is_idle;
   logic             cand_ans;
   logic             cand_true;
   logic             dispatch;
   logic             capture;

   logic             ans_q, true_q, to_beep_q, to_stop_q, busy_q, done_q;

   assign is_idle = (state_q == S_IDLE);

   // Candidates for the next sequence when one is chosen. In IDLE this is
   // the live request. At termination, with the queue, it also includes
   // queued flags and any request that arrives in the terminating cycle.
   // Without the queue, termination always returns to IDLE.
   assign cand_ans  = (Answer_Req & (is_idle | QUEUE_EN)) | pend_ans_q;
   assign cand_true = (True_Req   & (is_idle | QUEUE_EN)) | pend_true_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bcnt_d      = bcnt_q;
      done_d      = 1'b0;
      pend_ans_d  = pend_ans_q;
      pend_true_d = pend_true_q;
      dispatch    = 1'b0;
      capture     = 1'b0;

      if (Mute) begin
         state_d     = S_IDLE;
         cnt_d       = '0;
         bcnt_d      = '0;
         pend_ans_d  = 1'b0;
         pend_true_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (TimeOver_Req) begin
                  state_d = S_TO_ON;
                  cnt_d   = '0;
                  bcnt_d  = '0;
                  capture = 1'b1;
               end else begin
                  dispatch = 1'b1;
               end
            end

            S_ANS, S_TRUE: begin
               // Preemption: the aborted tone gives no Done.
               if (TimeOver_Req) begin
                  state_d = S_TO_ON;
                  cnt_d   = '0;
                  bcnt_d  = '0;
                  capture = 1'b1;
               end else if (cnt_q == ((state_q == S_ANS) ? ANS_LAST : TRUE_LAST)) begin
                  done_d   = 1'b1;
                  dispatch = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  capture = 1'b1;
               end
            end

            S_TO_ON: begin
               if (cnt_q == TO_ON_LAST) begin
                  if (bcnt_q == BEEPS_LAST) begin
                     done_d   = 1'b1;
                     dispatch = 1'b1;
                  end else begin
                     state_d = S_TO_OFF;
                     cnt_d   = '0;
                     bcnt_d  = bcnt_q + 4'd1;
                     capture = 1'b1;
                  end
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  capture = 1'b1;
               end
            end

            S_TO_OFF: begin
               if (cnt_q == TO_OFF_LAST) begin
                  state_d = S_TO_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               capture = 1'b1;
            end

            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               bcnt_d  = '0;
            end
         endcase

         // Requests that arrive while busy, or that lose to a time-over in
         // IDLE, are held. A repeat of a request already pending is simply
         // absorbed by the OR.
         if (capture) begin
            pend_ans_d  = QUEUE_EN & (pend_ans_q  | Answer_Req);
            pend_true_d = QUEUE_EN & (pend_true_q | True_Req);
         end

         // Choose the next sequence (IDLE or termination). A true request
         // that loses to an answer stays queued.
         if (dispatch) begin
            cnt_d = '0;
            if (cand_ans) begin
               state_d = S_ANS;
            end else if (cand_true) begin
               state_d = S_TRUE;
            end else begin
               state_d = S_IDLE;
            end
            pend_ans_d  = 1'b0;
            pend_true_d = QUEUE_EN & cand_ans & cand_true;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bcnt_q      <= '0;
         pend_ans_q  <= 1'b0;
         pend_true_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bcnt_q      <= bcnt_d;
         pend_ans_q  <= pend_ans_d;
         pend_true_q <= pend_true_d;
      end
   end

   // Outputs are registered from the next state, so they change on the same
   // edge as the state register and are glitch-free toward the tone generator.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ans_q     <= 1'b0;
         true_q    <= 1'b0;
         to_beep_q <= 1'b0;
         to_stop_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         ans_q     <= (state_d == S_ANS);
         true_q    <= (state_d == S_TRUE);
         to_beep_q <= (state_d == S_TO_ON);
         to_stop_q <= (state_d == S_TO_ON) || (state_d == S_TO_OFF);
         busy_q    <= (state_d != S_IDLE);
         done_q    <= done_d;
      end
   end

   assign Buzzer_Answer   = ans_q;
   assign Answer_true     = true_q;
   assign Buzzer_TimeOver = to_beep_q;
   assign TimeOver_Stop   = to_stop_q;
   assign Busy            = busy_q;
   assign Done            = done_q;

endmodule
